// File: rtl/risco_wb_bridge.sv
// Bridges the Baby-Risco-5 load/store port onto a Wishbone-classic master port.
// Sub-word stores use read-modify-write because the bus has no byte selects.
module risco_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_rd_i,
  input  logic                  mem_wr_i,
  input  logic [2:0]            mem_option_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_resp_o,
  output logic                  mem_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [31:0]           wb_data_o,
  input  logic [31:0]           wb_data_i,
  input  logic                  wb_ack_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, GAP, WR, RESP} state_t;

  state_t                state_q, state_d;
  logic [2:0]            opt_q, opt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           word_q, word_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [31:0]           wdo_q, wdo_d;
  logic                  resp_q, resp_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  erro_q, erro_d;

  logic                  ack_c, tmo_c, bad_c;
  logic [4:0]            sh_c;
  logic [31:0]           lane_c, mask_c, merged_c, load_c;

  // Request validation, lane alignment, load extension and store merge
  always_comb begin
    bad_c = (mem_rd_i & mem_wr_i)
          | (mem_option_i == 3'b011) | (mem_option_i[2:1] == 2'b11)
          | ((mem_option_i[1:0] == 2'b01) & mem_addr_i[0])
          | ((mem_option_i == 3'b010) & (mem_addr_i[1:0] != 2'b00));
    ack_c  = cyc_q & wb_ack_i;
    tmo_c  = cyc_q & ~wb_ack_i & (cnt_q == CNT_LAST);
    sh_c   = {addr_q[1:0], 3'b000};
    lane_c = wb_data_i >> sh_c;
    mask_c = (opt_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh_c;
    merged_c = (wb_data_i & ~mask_c) | ((word_q << sh_c) & mask_c);
    case (opt_q)
      3'b000:  load_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'b100:  load_c = {24'h0, lane_c[7:0]};
      3'b001:  load_c = {{16{lane_c[15]}}, lane_c[15:0]};
      3'b101:  load_c = {16'h0, lane_c[15:0]};
      default: load_c = wb_data_i;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    opt_d   = opt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    err_d   = err_q;
    cnt_d   = '0;
    cyc_d   = 1'b0;
    we_d    = 1'b0;
    wdo_d   = 32'h0;
    resp_d  = 1'b0;
    rdata_d = 32'h0;
    erro_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // resp_q high means the request on the inputs is the one just completed
        if ((mem_rd_i | mem_wr_i) & ~resp_q) begin
          opt_d  = mem_option_i;
          addr_d = mem_addr_i;
          word_d = mem_wdata_i;
          err_d  = 1'b0;
          if (bad_c) begin
            err_d   = 1'b1;
            word_d  = 32'h0;
            state_d = RESP;
          end else if (mem_rd_i) begin
            state_d = RD;
          end else if (mem_option_i == 3'b010) begin
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD, RMW_RD, WR: begin
        if (ack_c) begin
          case (state_q)
            RD:      begin word_d = load_c;   state_d = RESP; end
            RMW_RD:  begin word_d = merged_c; state_d = GAP;  end
            default: begin word_d = 32'h0;    state_d = RESP; end
          endcase
        end else if (tmo_c) begin
          err_d   = 1'b1;
          word_d  = 32'h0;
          state_d = RESP;
        end else begin
          cyc_d = 1'b1;
          we_d  = (state_q == WR);
          wdo_d = (state_q == WR) ? word_q : 32'h0;
          cnt_d = cyc_q ? cnt_q + CNT_W'(1) : '0;
        end
      end
      GAP: state_d = WR;
      RESP: begin
        resp_d  = 1'b1;
        rdata_d = word_q;
        erro_d  = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opt_q   <= 3'b000;
      addr_q  <= '0;
      word_q  <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      wdo_q   <= 32'h0;
      resp_q  <= 1'b0;
      rdata_q <= 32'h0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opt_q   <= opt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      wdo_q   <= wdo_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      erro_q  <= erro_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_addr_o   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign wb_data_o   = wdo_q;
  assign mem_resp_o  = resp_q;
  assign mem_rdata_o = rdata_q;
  assign mem_err_o   = erro_q;

endmodule

// File: doc/risco_wb_bridge.md
Name: risco_wb_bridge

Overview:
- Bridges the Baby-Risco-5 core's native load/store port to the Wishbone-classic bus that the Controller exposes as its core bus (cyc/stb/we/addr/data/ack).
- Sits directly between the core and the Controller in the processorci top.
- Handles word-aligned access, byte/halfword extraction with sign/zero extension, read-modify-write for sub-word stores (the bus has no byte selects), misalignment rejection and a bus timeout.

Parameters:
- TIMEOUT_CYCLES, 1024: wait cycles for ack before the access is aborted with an error.
- ADDR_WIDTH, 32: width of the address on both sides.

Ports:
- clk  in  1  clock; the core clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_rd_i  in  1  core load request.
- mem_wr_i  in  1  core store request.
- mem_option_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_addr_i  in  ADDR_WIDTH  byte address.
- mem_wdata_i  in  32  store data, right-aligned.
- mem_rdata_o  out  32  load result, extended.
- mem_resp_o  out  1  one-cycle completion pulse.
- mem_err_o  out  1  valid with mem_resp_o: misaligned, illegal option, rd&wr, or timeout.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  bus strobe.
- wb_we_o  out  1  bus write enable.
- wb_addr_o  out  ADDR_WIDTH  word address: mem_addr_i with bits [1:0] cleared.
- wb_data_o  out  32  write data.
- wb_data_i  in  32  read data.
- wb_ack_i  in  1  bus acknowledge.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0. Reset asserted mid-access drops cyc/stb asynchronously; no response pulse is issued.
- Request protocol: the core holds rd/wr, option, addr and wdata stable until mem_resp_o. All request fields are latched on the IDLE edge that accepts the request.
- FSM states: IDLE, RD, RMW_RD, GAP, WR, RESP.
- IDLE with a request:
  - rd&wr both high, option in {011,110,111}, or misalignment (H/HU with addr[0]=1; W with addr[1:0]!=0) -> RESP with err=1 and no bus activity.
  - Load -> RD.
  - Store W -> WR.
  - Store B/H -> RMW_RD.
- RD / RMW_RD / WR:
  - cyc=stb=1, registered, asserted the cycle after entry; we=1 only in WR.
  - On wb_ack_i, cyc/stb drop on the next edge.
  - RD -> RESP. Data is selected by addr[1:0] (byte lane, or halfword lane addr[1]) and sign- or zero-extended per option.
  - RMW_RD -> GAP, latching the merged word: the new byte/halfword replaces the lane given by addr, other lanes are kept.
  - WR -> RESP; rdata=0.
- GAP: one idle cycle (cyc=stb=0), then WR with the merged word.
- Latency with zero-wait ack (ack in the first stb cycle):
  - Load: request at edge N, stb high N+1, resp at N+3.
  - Word store: same as load.
  - Sub-word store: resp at N+6.
- RESP:
  - mem_resp_o=1 for exactly one cycle; rdata/err valid in that cycle only. rdata is 0 otherwise.
  - Returns to IDLE.
  - A request still asserted during RESP is NOT re-accepted; the core must drop it, and IDLE accepts only from the following edge.
- Timeout:
  - The counter clears on entry to each bus state and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack, cyc/stb drop and the FSM goes to RESP with err=1, rdata=0.
  - A sub-word store that times out during RMW_RD performs no write.
  - Ack arriving on the same cycle as the final count wins: normal completion.
- Ack received outside RD/RMW_RD/WR is ignored.
- wb_data_o is 0 except in WR.

Test Plan:
- LW @0x10, bus returns 0xDEADBEEF with ack on the 1st stb cycle -> wb_addr=0x10, we=0, resp at N+3, rdata=0xDEADBEEF, err=0.
- LB @0x13 and LBU @0x13, word 0x80FF1234 -> rdata=0xFFFFFF80, then 0x00000080. LH @0x12 -> 0xFFFF80FF.
- SB 0xAB @0x21, memory word 0x11223344 -> read phase at addr 0x20, one-cycle gap, write 0x1122AB44 with we=1, resp at N+6.
- SH @0x03 -> resp with err=1 and cyc never asserted. LW with rd=wr=1 -> err=1.
- TIMEOUT_CYCLES=8, no ack -> stb high exactly 8 cycles, then resp with err=1, rdata=0. For SB, no WR phase occurs.
- rst_n pulled low during the RMW_RD stb -> cyc/stb=0 immediately, no resp. After release, a fresh LW completes normally.
